// File: rtl/counter_mod.sv
// counter_mod
//   Free-running up-counter used as a timebase / sequence generator.
//   Counts 0,1,...,MAX_COUNT,0,... (period MAX_COUNT+1) once reset is low.
//
// Parameters
//   WIDTH      bit width of the count (1..32)
//   MAX_COUNT  last value before wrap (0 < MAX_COUNT <= 2^WIDTH-1)
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   counter       out  [WIDTH-1:0] registered count value
//   tc            out  terminal count, combinational, high while counter == MAX_COUNT
//   wrap          out  registered one-cycle pulse after counter wrapped MAX_COUNT -> 0
//   counter_gray  out  [WIDTH-1:0] registered Gray encoding of counter
//                      (present only when COUNTER_GRAY_OUT_EN is defined)
//
// Optional feature macro: COUNTER_GRAY_OUT_EN

module counter_mod #(
  parameter int unsigned     WIDTH     = 4,
  parameter longint unsigned MAX_COUNT = 15
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             wrap
`ifdef COUNTER_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] counter_gray
`endif
);

  localparam longint unsigned LIMIT = (64'd1 << WIDTH) - 64'd1;

  // Illegal parameter combinations stop elaboration with a message.
  generate
    if ((WIDTH < 1) || (WIDTH > 32) || (MAX_COUNT == 0) || (MAX_COUNT > LIMIT)) begin : g_bad_params
      $error("counter_mod: illegal parameters WIDTH=%0d MAX_COUNT=%0d", WIDTH, MAX_COUNT);
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_max;

  // The explicit compare is kept even when MAX_COUNT is the natural
  // rollover value, so both cases share one datapath.
  always_comb begin
    at_max  = (count_q == MAX_W);
    count_d = at_max ? '0 : count_q + WIDTH'(1);
    wrap_d  = at_max;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign counter = count_q;
  assign tc      = at_max;
  assign wrap    = wrap_q;

`ifdef COUNTER_GRAY_OUT_EN
  logic [WIDTH-1:0] gray_q;

  // Encoded from the next count so the Gray value lands on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gray_q <= '0;
    end else begin
      gray_q <= count_d ^ (count_d >> 1);
    end
  end

  assign counter_gray = gray_q;
`endif

endmodule

// File: tb/tb_counter_mod.sv
module tb_counter_mod;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cnt15, cnt9;
  logic       tc15, tc9, wrap15, wrap9;
`ifdef COUNTER_GRAY_OUT_EN
  logic [3:0] gray15, gray9;
  logic [3:0] prev_gray;
  bit         prev_valid = 1'b0;
`endif

  int unsigned n_edges  = 0;
  int          n_checks = 0;
  int          n_pass   = 0;

  counter_mod #(.WIDTH(4), .MAX_COUNT(15)) u_dut15 (
    .clk          (clk),
    .reset        (reset),
    .counter      (cnt15),
    .tc           (tc15),
    .wrap         (wrap15)
`ifdef COUNTER_GRAY_OUT_EN
    ,
    .counter_gray (gray15)
`endif
  );

  counter_mod #(.WIDTH(4), .MAX_COUNT(9)) u_dut9 (
    .clk          (clk),
    .reset        (reset),
    .counter      (cnt9),
    .tc           (tc9),
    .wrap         (wrap9)
`ifdef COUNTER_GRAY_OUT_EN
    ,
    .counter_gray (gray9)
`endif
  );

  always #5 clk = ~clk;

  // Reference: number of rising edges seen with reset low since the last
  // edge that saw reset high. Everything else is derived arithmetically.
  always @(posedge clk) n_edges <= reset ? 0 : n_edges + 1;

  function automatic int exp_cnt(input int m);
    return reset ? 0 : int'(n_edges % (m + 1));
  endfunction

  function automatic bit exp_wrap(input int m);
    return !reset && (n_edges > 0) && ((n_edges % (m + 1)) == 0);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    int e15, e9;
    e15 = exp_cnt(15);
    e9  = exp_cnt(9);
    check("cnt15",  cnt15,  e15);
    check("tc15",   tc15,   (e15 == 15));
    check("wrap15", wrap15, exp_wrap(15));
    check("cnt9",   cnt9,   e9);
    check("tc9",    tc9,    (e9 == 9));
    check("wrap9",  wrap9,  exp_wrap(9));
    check("cnt9_range", (cnt9 <= 4'd9), 1);
`ifdef COUNTER_GRAY_OUT_EN
    check("gray15", gray15, e15 ^ (e15 >> 1));
    check("gray9",  gray9,  e9 ^ (e9 >> 1));
`endif
  endtask

  task automatic step_check();
    @(negedge clk);
    check_all();
`ifdef COUNTER_GRAY_OUT_EN
    if (!reset && prev_valid && n_edges > 0)
      check("gray15_hamming", $countones(gray15 ^ prev_gray), 1);
    prev_gray  = gray15;
    prev_valid = !reset;
`endif
  endtask

  // Reset asserted 'off' ns after a rising edge, checked 1 ns later (before
  // any edge), held for 'hold' edges, released 'rel' ns after the last one.
  task automatic async_reset(input int off, input int hold, input int rel);
    @(posedge clk);
    #(off);
    reset = 1'b1;
    #1;
    check_all();
`ifdef COUNTER_GRAY_OUT_EN
    prev_valid = 1'b0;
`endif
    repeat (hold) @(posedge clk);
    #(rel);
    reset = 1'b0;
  endtask

  initial begin
    int wrap_at[$];
    int run_len;

    // Reset held over the first two edges.
    step_check();
    step_check();
    check("cnt_in_reset", cnt15, 0);
    reset = 1'b0;                         // released at 20 ns
    step_check();
    check("cnt_first_edge", cnt15, 1);    // after 25 ns edge
    repeat (7) step_check();
    check("cnt_at_100ns", cnt15, 8);

    // Asynchronous reset at 102 ns, release at 118 ns.
    #2 reset = 1'b1;
    #1;
    check("cnt_async_clear", cnt15, 0);
    check("wrap_async_clear", wrap15, 0);
    #15 reset = 1'b0;
    step_check();                         // 120 ns: 115 edge saw reset
    step_check();                         // 130 ns
    check("cnt_after_release", cnt15, 1);
    check("no_wrap_after_release", wrap15, 0);

    // Run through more than one full period of both counters.
    repeat (40) step_check();

    // Randomized runs interleaved with asynchronous resets.
    for (int it = 0; it < 40; it++) begin
      run_len = $urandom_range(1, 45);
      repeat (run_len) step_check();
      async_reset($urandom_range(1, 4), $urandom_range(1, 3), $urandom_range(1, 4));
    end
    repeat (5) step_check();

    // Reset held, then exactly three full periods of the MAX_COUNT=15 counter.
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step_check();
    reset = 1'b0;
    for (int i = 0; i < 48; i++) begin
      step_check();
      if (wrap15) wrap_at.push_back(i);
    end
    check("wrap_pulse_count", wrap_at.size(), 3);
    if (wrap_at.size() == 3) begin
      check("wrap_spacing_1", wrap_at[1] - wrap_at[0], 16);
      check("wrap_spacing_2", wrap_at[2] - wrap_at[1], 16);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
